// File: rtl/sram_axi_slave.sv
// sram_axi_slave
//   AXI4 responder in front of one synchronous single-port 32-bit SRAM.
//   One transaction at a time; every response is OKAY. The word address is
//   addr[SRAM_AW+1:2]. All other address bits, and AxSIZE and WLAST, are ignored.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   aw*/w*/b*                AXI write address / data / response channels
//   ar*/r*                   AXI read address / data channels
//   sram_cs, sram_oe         chip select / output enable (active-high)
//   sram_web                 per-byte write enable (active-low)
//   sram_a, sram_di          word address / write data
//   sram_do                  read data, valid the cycle after cs&oe
module sram_axi_slave #(
  parameter int ID_W    = 8,
  parameter int ADDR_W  = 32,
  parameter int SRAM_AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ID_W-1:0]    awid,
  input  logic [ADDR_W-1:0]  awaddr,
  input  logic [3:0]         awlen,
  input  logic [2:0]         awsize,
  input  logic [1:0]         awburst,
  input  logic               awvalid,
  output logic               awready,
  input  logic [31:0]        wdata,
  input  logic [3:0]         wstrb,
  input  logic               wlast,
  input  logic               wvalid,
  output logic               wready,
  output logic [ID_W-1:0]    bid,
  output logic [1:0]         bresp,
  output logic               bvalid,
  input  logic               bready,
  input  logic [ID_W-1:0]    arid,
  input  logic [ADDR_W-1:0]  araddr,
  input  logic [3:0]         arlen,
  input  logic [2:0]         arsize,
  input  logic [1:0]         arburst,
  input  logic               arvalid,
  output logic               arready,
  output logic [ID_W-1:0]    rid,
  output logic [31:0]        rdata,
  output logic [1:0]         rresp,
  output logic               rlast,
  output logic               rvalid,
  input  logic               rready,
  output logic               sram_cs,
  output logic               sram_oe,
  output logic [3:0]         sram_web,
  output logic [SRAM_AW-1:0] sram_a,
  output logic [31:0]        sram_di,
  input  logic [31:0]        sram_do
);

  typedef enum logic [2:0] {IDLE, R_FETCH, R_DATA, W_DATA, W_RESP} state_t;

  // Latched request fields, shared by reads and writes.
  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [SRAM_AW-1:0] addr;
    logic [3:0]         len;
    logic [1:0]         burst;
  } req_t;

  state_t     state_q, state_d;
  req_t       req_q, req_d;
  logic [3:0] cnt_q, cnt_d;

  // These inputs are ignored by design; fold them into one sink signal.
  logic unused_inputs;
  assign unused_inputs = ^{awsize, arsize, wlast, awaddr, araddr};

  // FIXED keeps the address. INCR and WRAP both step by one word and roll over
  // at the top of the SRAM.
  function automatic logic [SRAM_AW-1:0] next_addr(input logic [SRAM_AW-1:0] a,
                                                   input logic [1:0]         b);
    return (b == 2'b00) ? a : a + {{(SRAM_AW-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    cnt_d    = cnt_q;
    awready  = 1'b0;
    arready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    bid      = '0;
    rvalid   = 1'b0;
    rid      = '0;
    rdata    = '0;
    rlast    = 1'b0;
    sram_cs  = 1'b0;
    sram_oe  = 1'b0;
    sram_web = 4'hF;
    sram_a   = '0;
    sram_di  = '0;
    unique case (state_q)
      IDLE: begin
        awready = 1'b1;
        // Write wins a tie, so hold off the read while AW is pending.
        arready = ~awvalid;
        if (awvalid) begin
          req_d   = '{id: awid, addr: awaddr[SRAM_AW+1:2], len: awlen, burst: awburst};
          cnt_d   = '0;
          state_d = W_DATA;
        end else if (arvalid) begin
          req_d   = '{id: arid, addr: araddr[SRAM_AW+1:2], len: arlen, burst: arburst};
          cnt_d   = '0;
          state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        sram_cs = 1'b1;
        sram_oe = 1'b1;
        sram_a  = req_q.addr;
        state_d = R_DATA;
      end
      R_DATA: begin
        // Keep the SRAM read request up so sram_do holds through an R stall.
        sram_cs = 1'b1;
        sram_oe = 1'b1;
        sram_a  = req_q.addr;
        rvalid  = 1'b1;
        rdata   = sram_do;
        rid     = req_q.id;
        rlast   = (cnt_q == req_q.len);
        if (rready) begin
          if (cnt_q == req_q.len) begin
            state_d = IDLE;
          end else begin
            cnt_d      = cnt_q + 4'd1;
            req_d.addr = next_addr(req_q.addr, req_q.burst);
            state_d    = R_FETCH;
          end
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          sram_cs  = 1'b1;
          sram_web = ~wstrb;
          sram_a   = req_q.addr;
          sram_di  = wdata;
          // The beat count alone ends the burst; wlast is not consulted.
          if (cnt_q == req_q.len) begin
            state_d = W_RESP;
          end else begin
            cnt_d      = cnt_q + 4'd1;
            req_d.addr = next_addr(req_q.addr, req_q.burst);
          end
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        bid    = req_q.id;
        if (bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bresp = 2'b00;
  assign rresp = 2'b00;

endmodule

// File: tb/tb_sram_axi_slave.sv
module tb_sram_axi_slave;
  logic        clk = 0;
  logic        rst = 1;
  logic [7:0]  awid = 0, arid = 0;
  logic [31:0] awaddr = 0, araddr = 0;
  logic [3:0]  awlen = 0, arlen = 0;
  logic [2:0]  awsize = 3'd2, arsize = 3'd2;
  logic [1:0]  awburst = 0, arburst = 0;
  logic        awvalid = 0, arvalid = 0;
  logic        awready, arready;
  logic [31:0] wdata = 0;
  logic [3:0]  wstrb = 0;
  logic        wlast = 0, wvalid = 0, wready;
  logic [7:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready = 0;
  logic [31:0] rdata;
  logic        rlast, rvalid, rready = 0;
  logic        sram_cs, sram_oe;
  logic [3:0]  sram_web;
  logic [13:0] sram_a;
  logic [31:0] sram_di, sram_do = 0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] mem [0:16383];

  sram_axi_slave #(.ID_W(8), .ADDR_W(32), .SRAM_AW(14)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web), .sram_a(sram_a),
    .sram_di(sram_di), .sram_do(sram_do)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port SRAM model.
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_oe) sram_do <= mem[sram_a];
      for (int b = 0; b < 4; b++)
        if (!sram_web[b]) mem[sram_a][8*b +: 8] = sram_di[8*b +: 8];
    end
  end

  // ---------------- channel drivers (no checking) ----------------
  task automatic aw_hs(input logic [7:0] id, input logic [31:0] a, input logic [3:0] len,
                       input logic [1:0] burst, output logic to);
    int n;
    @(negedge clk);
    awid = id; awaddr = a; awlen = len; awburst = burst; awvalid = 1;
    #1; n = 0;
    while (!awready && n < 20) begin @(negedge clk); #1; n++; end
    to = !awready;
    @(posedge clk); #1 awvalid = 0;
  endtask

  task automatic ar_hs(input logic [7:0] id, input logic [31:0] a, input logic [3:0] len,
                       input logic [1:0] burst, output int hs, output logic to);
    int n;
    @(negedge clk);
    arid = id; araddr = a; arlen = len; arburst = burst; arvalid = 1;
    #1; n = 0;
    while (!arready && n < 20) begin @(negedge clk); #1; n++; end
    to = !arready; hs = cyc;
    @(posedge clk); #1 arvalid = 0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l,
                        output logic [3:0] web, output logic [13:0] a, output logic [31:0] di,
                        output logic to);
    int n;
    @(negedge clk);
    wdata = d; wstrb = s; wlast = l; wvalid = 1;
    #1; n = 0;
    while (!wready && n < 20) begin @(negedge clk); #1; n++; end
    to = !wready; web = sram_web; a = sram_a; di = sram_di;
    @(posedge clk); #1 wvalid = 0;
  endtask

  task automatic b_wait(output logic [7:0] id, output logic [1:0] resp, output int waits,
                        output logic [3:0] web, output logic to);
    int n;
    @(negedge clk);
    bready = 1;
    #1; n = 0; web = sram_web;
    while (!bvalid && n < 20) begin @(negedge clk); #1; n++; end
    to = !bvalid; waits = n; id = bid; resp = bresp;
    @(posedge clk); #1 bready = 0;
  endtask

  task automatic r_beat(input int stall, output logic [31:0] d, output logic [7:0] id,
                        output logic [1:0] resp, output logic last, output logic stable,
                        output int vcyc, output logic to);
    int n;
    logic [31:0] sd;
    logic [7:0] sid;
    logic sl;
    @(negedge clk); #1; n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); #1; n++; end
    to = !rvalid; vcyc = cyc; sd = rdata; sid = rid; sl = rlast; stable = 1;
    repeat (stall) begin
      @(negedge clk); #1;
      if (!rvalid || rdata !== sd || rid !== sid || rlast !== sl) stable = 0;
    end
    d = rdata; id = rid; resp = rresp; last = rlast;
    rready = 1;
    @(posedge clk); #1 rready = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    checks++;
    if ({awready, arready, wready, bvalid, rvalid, rlast, sram_cs, sram_oe} !== 8'b1100_0000) begin
      failures++; $display("FAIL reset_ctrl got %b exp 11000000",
        {awready, arready, wready, bvalid, rvalid, rlast, sram_cs, sram_oe});
    end
    checks++;
    if (sram_web !== 4'hF || sram_a !== 14'd0 || sram_di !== 32'd0 || rdata !== 32'd0 ||
        bid !== 8'd0 || rid !== 8'd0) begin
      failures++; $display("FAIL reset_data got web=%h a=%h di=%h rdata=%h bid=%h rid=%h",
        sram_web, sram_a, sram_di, rdata, bid, rid);
    end
    awvalid = 1; #1;
    checks++;
    if (arready !== 1'b0 || awready !== 1'b1) begin
      failures++; $display("FAIL reset_arready got ar=%b aw=%b exp 0 1", arready, awready);
    end
    awvalid = 0;
    @(negedge clk); rst = 0;
  endtask

  task automatic test_single_read();
    int hs, vc; logic to, last, st; logic [31:0] d; logic [7:0] id; logic [1:0] rs;
    ar_hs(8'h13, 32'h40, 4'd0, 2'b01, hs, to);
    r_beat(0, d, id, rs, last, st, vc, to);
    checks++;
    if (to !== 1'b0 || vc - hs != 2) begin
      failures++; $display("FAIL sread_latency got %0d exp 2 (timeout %b)", vc - hs, to);
    end
    checks++;
    if (d !== 32'hDEADBEEF || id !== 8'h13 || rs !== 2'b00 || last !== 1'b1) begin
      failures++; $display("FAIL sread_beat got d=%h id=%h resp=%b last=%b exp deadbeef 13 00 1",
        d, id, rs, last);
    end
  endtask

  task automatic test_incr_read_stall();
    int hs, vc; logic to, last, st; logic [31:0] d; logic [7:0] id; logic [1:0] rs;
    logic [31:0] exp_d;
    ar_hs(8'h21, 32'h100, 4'd3, 2'b01, hs, to);
    for (int b = 0; b < 4; b++) begin
      r_beat((b == 1) ? 3 : 0, d, id, rs, last, st, vc, to);
      exp_d = 32'hA000_0040 + b;
      checks++;
      if (to !== 1'b0 || d !== exp_d || id !== 8'h21 || last !== (b == 3)) begin
        failures++; $display("FAIL iread_beat%0d got d=%h id=%h last=%b exp %h 21 %b",
          b, d, id, last, exp_d, (b == 3));
      end
      if (b == 1) begin
        checks++;
        if (st !== 1'b1) begin
          failures++; $display("FAIL iread_stall_stable got %b exp 1", st);
        end
      end
    end
  endtask

  task automatic test_single_write();
    logic to; logic [3:0] web, web_b; logic [13:0] a; logic [31:0] di; logic [7:0] id;
    logic [1:0] rs; int w, hs, vc; logic last, st; logic [31:0] d;
    aw_hs(8'h5C, 32'h40, 4'd0, 2'b01, to);
    w_beat(32'h11223344, 4'b0011, 1'b1, web, a, di, to);
    checks++;
    if (to !== 1'b0 || web !== 4'b1100 || a !== 14'h10 || di !== 32'h11223344) begin
      failures++; $display("FAIL swrite_strobe got web=%b a=%h di=%h exp 1100 0010 11223344",
        web, a, di);
    end
    b_wait(id, rs, w, web_b, to);
    checks++;
    if (to !== 1'b0 || w != 0 || id !== 8'h5C || rs !== 2'b00 || web_b !== 4'hF) begin
      failures++; $display("FAIL swrite_b got waits=%0d bid=%h bresp=%b web=%b exp 0 5c 00 1111",
        w, id, rs, web_b);
    end
    ar_hs(8'h01, 32'h40, 4'd0, 2'b01, hs, to);
    r_beat(0, d, id, rs, last, st, vc, to);
    checks++;
    if (d !== 32'hFFFF3344) begin
      failures++; $display("FAIL swrite_readback got %h exp ffff3344", d);
    end
  endtask

  task automatic test_simultaneous();
    logic to; logic [3:0] web, web_b; logic [13:0] a; logic [31:0] di; logic [7:0] id;
    logic [1:0] rs; int w, vc, hs, n; logic last, st; logic [31:0] d;
    @(negedge clk);
    awid = 8'h77; awaddr = 32'h300; awlen = 0; awburst = 2'b01; awvalid = 1;
    arid = 8'h88; araddr = 32'h300; arlen = 0; arburst = 2'b01; arvalid = 1;
    #1;
    checks++;
    if (awready !== 1'b1 || arready !== 1'b0) begin
      failures++; $display("FAIL simul_ready got aw=%b ar=%b exp 1 0", awready, arready);
    end
    @(posedge clk); #1 awvalid = 0;
    @(negedge clk); #1;
    checks++;
    if (arready !== 1'b0 || awready !== 1'b0 || wready !== 1'b1) begin
      failures++; $display("FAIL simul_wdata_ready got ar=%b aw=%b w=%b exp 0 0 1",
        arready, awready, wready);
    end
    w_beat(32'hCAFEF00D, 4'hF, 1'b1, web, a, di, to);
    b_wait(id, rs, w, web_b, to);
    checks++;
    if (to !== 1'b0 || id !== 8'h77 || rs !== 2'b00) begin
      failures++; $display("FAIL simul_b got bid=%h bresp=%b exp 77 00", id, rs);
    end
    @(negedge clk); #1; n = 0;
    while (!arready && n < 20) begin @(negedge clk); #1; n++; end
    hs = cyc;
    @(posedge clk); #1 arvalid = 0;
    r_beat(0, d, id, rs, last, st, vc, to);
    checks++;
    if (to !== 1'b0 || d !== 32'hCAFEF00D || id !== 8'h88 || last !== 1'b1) begin
      failures++; $display("FAIL simul_read got d=%h id=%h last=%b exp cafef00d 88 1", d, id, last);
    end
  endtask

  task automatic test_fixed_write();
    logic to; logic [3:0] web, web_b; logic [13:0] a; logic [31:0] di; logic [7:0] id;
    logic [1:0] rs; int w, hs, vc; logic last, st; logic [31:0] d;
    aw_hs(8'h02, 32'h200, 4'd2, 2'b00, to);
    for (int b = 0; b < 3; b++) begin
      w_beat(32'(b + 1), 4'hF, (b == 2), web, a, di, to);
      checks++;
      if (to !== 1'b0 || a !== 14'h80 || web !== 4'h0) begin
        failures++; $display("FAIL fixed_addr%0d got a=%h web=%b exp 0080 0000", b, a, web);
      end
    end
    b_wait(id, rs, w, web_b, to);
    ar_hs(8'h03, 32'h200, 4'd0, 2'b00, hs, to);
    r_beat(0, d, id, rs, last, st, vc, to);
    checks++;
    if (d !== 32'd3) begin
      failures++; $display("FAIL fixed_readback got %h exp 00000003", d);
    end
  endtask

  task automatic test_wrap_write();
    logic to; logic [3:0] web, web_b; logic [13:0] a0, a1; logic [31:0] di; logic [7:0] id;
    logic [1:0] rs; int w;
    aw_hs(8'h04, 32'h0000_FFFC, 4'd1, 2'b01, to);
    w_beat(32'h0000_AAAA, 4'hF, 1'b0, web, a0, di, to);
    w_beat(32'h0000_BBBB, 4'hF, 1'b1, web, a1, di, to);
    checks++;
    if (a0 !== 14'h3FFF || a1 !== 14'h0000) begin
      failures++; $display("FAIL wrap_addr got %h,%h exp 3fff,0000", a0, a1);
    end
    b_wait(id, rs, w, web_b, to);
    checks++;
    if (to !== 1'b0 || mem[14'h3FFF] !== 32'h0000AAAA || mem[0] !== 32'h0000BBBB) begin
      failures++; $display("FAIL wrap_mem got %h,%h exp 0000aaaa,0000bbbb", mem[14'h3FFF], mem[0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    int hs, vc, n; logic to, last, st; logic [31:0] d; logic [7:0] id; logic [1:0] rs;
    logic stale;
    ar_hs(8'h31, 32'h100, 4'd3, 2'b01, hs, to);
    r_beat(0, d, id, rs, last, st, vc, to);
    @(negedge clk); #1; n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); #1; n++; end
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hA0000041) begin
      failures++; $display("FAIL rstmid_beat2 got rvalid=%b d=%h exp 1 a0000041", rvalid, rdata);
    end
    rst = 1; #1;
    checks++;
    if ({rvalid, rlast, sram_cs, sram_oe, awready, arready} !== 6'b000011 ||
        sram_web !== 4'hF || sram_a !== 14'd0 || rdata !== 32'd0 || rid !== 8'd0) begin
      failures++; $display("FAIL rstmid_outputs got rv=%b rl=%b cs=%b oe=%b aw=%b ar=%b web=%b a=%h d=%h rid=%h",
        rvalid, rlast, sram_cs, sram_oe, awready, arready, sram_web, sram_a, rdata, rid);
    end
    @(negedge clk); rst = 0;
    stale = 0;
    repeat (3) begin @(negedge clk); #1; if (rvalid || bvalid) stale = 1; end
    checks++;
    if (stale !== 1'b0) begin
      failures++; $display("FAIL rstmid_stale got 1 exp 0");
    end
    ar_hs(8'h32, 32'h44, 4'd0, 2'b01, hs, to);
    r_beat(0, d, id, rs, last, st, vc, to);
    checks++;
    if (to !== 1'b0 || vc - hs != 2 || d !== 32'h5A5AA5A5 || id !== 8'h32 || last !== 1'b1) begin
      failures++; $display("FAIL rstmid_after got lat=%0d d=%h id=%h last=%b exp 2 5a5aa5a5 32 1",
        vc - hs, d, id, last);
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    mem[14'h10] = 32'hDEADBEEF;
    mem[14'h11] = 32'h5A5AA5A5;
    for (int i = 0; i < 4; i++) mem[14'h40 + i] = 32'hA000_0040 + i;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_read();
    test_incr_read_stall();
    mem[14'h10] = 32'hFFFFFFFF;
    test_single_write();
    test_simultaneous();
    test_fixed_write();
    test_wrap_write();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
